cellram_responder: RTL
======================

# cellram_responder

Synthesizable responder for the cellular-RAM side of the memory bus that the memory arbitrator drives. It is used in cosim and on-FPGA test builds in place of the external CellularRAM. It decodes bus-configuration-register (BCR) writes, enforces the programmed initial latency through `mem_wait`, and services synchronous write and read bursts against an internal 16-bit block RAM. Burst-length and wrap semantics are taken from the BCR.

## Interface
- `ADDR_WIDTH`, 23: word address width on `mem_addr`.
- `DEPTH_LOG2`, 12: implemented storage is 2^DEPTH_LOG2 words. Upper address bits are ignored (aliasing).
- `BCR_RESET`, 23'h081D0F: BCR value after reset.
- `clk`  in  1: memory clock; it is the arbitrator's `mem_clk`. All logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low.
- `mem_addr`  in  ADDR_WIDTH: burst start address, or BCR value when `mem_cre`=1.
- `mem_data_in`  in  16: write data from the initiator.
- `mem_data_out`  out  16: read data. Reset 0.
- `mem_data_oe`  out  1: read data valid and driving. Reset 0.
- `mem_ce`  in  1: chip enable, active-high.
- `mem_we`  in  1: 1 = write burst, 0 = read burst. Sampled at burst start.
- `mem_oe`  in  1: read output enable. `mem_data_oe` = internal read-valid & `mem_oe`.
- `mem_addr_valid`  in  1: burst-start strobe.
- `mem_cre`  in  1: configuration-register enable.
- `mem_wait`  out  1: 1 = ready, 0 = latency/config busy. Reset 1.
- `bcr`  out  23: current BCR, for debug. Reset `BCR_RESET`.

## Operation
- FSM states: IDLE, CONFIG, LATENCY, BURST_WR, BURST_RD.
- **IDLE**
  - `mem_cre`=1 and `mem_ce`=1: latch `mem_addr` into `bcr` and go to CONFIG. `mem_wait`=0 for exactly 2 cycles, then 1; return to IDLE.
  - Otherwise, `mem_addr_valid`=1 and `mem_ce`=1: latch start address and direction.
- **Latency** LAT = `bcr[13:11]`.
  - LAT=0: enter BURST_* the next cycle.
  - Otherwise go to LATENCY with `mem_wait`=0 for LAT cycles, then BURST_*.
- **Burst length** from `bcr[2:0]`: 001=4, 010=8, 011=16, 100=32; any other code = continuous.
- **Wrap** (`bcr[3]`=0): the address wraps inside the length-aligned block, e.g. len 4 starting at 6 gives 6,7,4,5. With `bcr[3]`=1, the address increments linearly modulo 2^DEPTH_LOG2.
- **BURST_WR**: every cycle with `mem_ce`=1 writes `mem_data_in` to the current address, then advances the address.
- **BURST_RD**: every cycle with `mem_ce`=1 presents the current word, then advances.
- **Burst end**:
  - Fixed-length burst: after `len` beats, return to IDLE. Further beats are ignored; `mem_data_oe` drops.
  - `mem_ce`=0 in any non-IDLE state aborts to IDLE the next cycle and sets `mem_wait`=1. A write beat is not committed on that cycle.
- **Priority**: `mem_cre` over `mem_addr_valid` over beat processing. `mem_addr_valid`=1 during a burst restarts a new burst, using that cycle's address and `mem_we`.
- **Reset mid-operation**: FSM goes to IDLE, outputs take their reset values, `bcr`=BCR_RESET. RAM contents are left unchanged.

## Timing
- Burst start strobe at edge k. Data beat 0 occurs at edge k+1+LAT, and `mem_wait` returns to 1 in that same cycle.
- Read data path: the RAM read is issued one cycle ahead, using `mem_addr` directly in the latch cycle when LAT=0. Beat n data is valid on `mem_data_out` in the cycle following edge k+1+LAT+n, with `mem_data_oe`=1.
- Write data is sampled at edge k+1+LAT+n.
- CONFIG: `bcr` updates at edge k. New latency and length apply to bursts starting at k+3 or later.

## Structure
- Shared cosim package holds:
  - BCR field constants: LAT_MSB/LSB=13/11, WRAP_BIT=3, LEN_MSB/LSB=2/0.
  - The length decode function.
  - The FSM state enum.
- One sub-module, `cellram_bram` (single-port, sync read, write-first, 2^DEPTH_LOG2 x16). The responder holds the FSM, burst counter and address generator.

## Test plan
- **Reset**: hold `reset`=0 mid-burst → `mem_wait`=1, `mem_data_oe`=0, `bcr`=23'h081D0F immediately, asynchronously.
- **Config write**: `mem_cre`=1, `mem_ce`=1, `mem_addr`=23'h000811 → `bcr`=23'h000811, and `mem_wait` is 0 for exactly 2 cycles.
- **Write then read**:
  - Write burst at addr 0x10 with LAT=3, continuous, 8 beats 0xA000..0xA007.
  - Read back from 0x10 → `mem_wait` low for 3 cycles, then 0xA000..0xA007 on consecutive cycles.
- **Wrap**: BCR len=4 (001), wrap on; read from addr 6 → words for addresses 6,7,4,5, then `mem_data_oe`=0.
- **Abort**: drop `mem_ce` after 2 write beats → only 2 words change, FSM is in IDLE, `mem_wait`=1.
- **Restart and priority**:
  - Assert `mem_addr_valid` mid-read burst → new burst with new latency count.
  - Assert `mem_cre` and `mem_addr_valid` together → CONFIG is taken and no burst starts.

Source files
------------

// File: rtl/cellram_responder_pkg.sv
// Shared definitions for the CellularRAM responder: BCR field positions,
// burst-length decode and the responder FSM state encoding.
package cellram_responder_pkg;

    localparam int unsigned LAT_MSB  = 13;
    localparam int unsigned LAT_LSB  = 11;
    localparam int unsigned WRAP_BIT = 3;
    localparam int unsigned LEN_MSB  = 2;
    localparam int unsigned LEN_LSB  = 0;

    typedef enum logic [2:0] {
        StIdle,
        StConfig,
        StLatency,
        StBurstWr,
        StBurstRd
    } state_e;

    // Returns the burst length in words; 0 means continuous.
    function automatic logic [5:0] len_decode(input logic [2:0] code);
        case (code)
            3'b001:  return 6'd4;
            3'b010:  return 6'd8;
            3'b011:  return 6'd16;
            3'b100:  return 6'd32;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/cellram_responder_if.sv
// Memory-bus signals between the arbitrator (master) and the CellularRAM
// responder (slave).
interface cellram_responder_if #(
    parameter int unsigned ADDR_WIDTH = 23
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_data_in;
    logic [15:0]           mem_data_out;
    logic                  mem_data_oe;
    logic                  mem_ce;
    logic                  mem_we;
    logic                  mem_oe;
    logic                  mem_addr_valid;
    logic                  mem_cre;
    logic                  mem_wait;

    modport master (
        output mem_addr, mem_data_in, mem_ce, mem_we, mem_oe, mem_addr_valid, mem_cre,
        input  mem_data_out, mem_data_oe, mem_wait
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_ce, mem_we, mem_oe, mem_addr_valid, mem_cre,
        output mem_data_out, mem_data_oe, mem_wait
    );
endinterface

// File: rtl/cellram_bram.sv
// Single-port 16-bit block RAM with synchronous, write-first read.
module cellram_bram #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);
    logic [15:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/cellram_responder.sv
// CellularRAM stand-in: BCR decode, initial-latency wait, and wrapped or
// linear synchronous bursts against an internal block RAM.
module cellram_responder
    import cellram_responder_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 23,
    parameter int unsigned           DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BCR_RESET  = 23'h081D0F
) (
    input  logic                  clk,
    input  logic                  reset,
    cellram_responder_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] bcr
);
    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [5:0]              beat_q, beat_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic                    dir_q, dir_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0]   bcr_q, bcr_d;

    logic [2:0]              lat;
    logic [5:0]              len;
    logic                    wrap;
    logic [DEPTH_LOG2-1:0]   addr_inc, len_mask, addr_next;
    logic                    last_beat;
    logic                    ram_we;
    logic [15:0]             ram_rdata;

    assign lat  = bcr_q[LAT_MSB:LAT_LSB];
    assign len  = len_decode(bcr_q[LEN_MSB:LEN_LSB]);
    assign wrap = !bcr_q[WRAP_BIT] && (len != 6'd0);

    // Wrapped bursts only advance the low bits inside the length-aligned block.
    assign addr_inc  = addr_q + DEPTH_LOG2'(1);
    assign len_mask  = DEPTH_LOG2'(len - 6'd1);
    assign addr_next = wrap ? ((addr_q & ~len_mask) | (addr_inc & len_mask)) : addr_inc;
    assign last_beat = (len != 6'd0) && (beat_q == len - 6'd1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        dir_d      = dir_q;
        bcr_d      = bcr_q;
        rd_valid_d = 1'b0;
        ram_we     = 1'b0;

        if (state_q == StConfig) begin
            if (!bus.mem_ce || cnt_q == 3'd0) begin
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else if (bus.mem_ce && bus.mem_cre) begin
            bcr_d   = bus.mem_addr;
            cnt_d   = 3'd1;
            state_d = StConfig;
        end else if (bus.mem_ce && bus.mem_addr_valid) begin
            addr_d = bus.mem_addr[DEPTH_LOG2-1:0];
            dir_d  = bus.mem_we;
            beat_d = 6'd0;
            if (lat == 3'd0) begin
                state_d = bus.mem_we ? StBurstWr : StBurstRd;
            end else begin
                cnt_d   = lat - 3'd1;
                state_d = StLatency;
            end
        end else if (state_q != StIdle && !bus.mem_ce) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StLatency: begin
                    if (cnt_q == 3'd0) begin
                        state_d = dir_q ? StBurstWr : StBurstRd;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                StBurstWr, StBurstRd: begin
                    ram_we     = (state_q == StBurstWr);
                    rd_valid_d = (state_q == StBurstRd);
                    addr_d     = addr_next;
                    beat_d     = beat_q + 6'd1;
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            beat_q     <= 6'd0;
            addr_q     <= '0;
            dir_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            bcr_q      <= BCR_RESET;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            dir_q      <= dir_d;
            rd_valid_q <= rd_valid_d;
            bcr_q      <= bcr_d;
        end
    end

    // The RAM is addressed by the current beat address, so read data lands
    // on the edge that processes the beat.
    cellram_bram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (bus.mem_data_in),
        .rdata (ram_rdata)
    );

    assign bus.mem_wait     = !(state_q == StLatency || state_q == StConfig);
    assign bus.mem_data_oe  = rd_valid_q & bus.mem_oe;
    assign bus.mem_data_out = rd_valid_q ? ram_rdata : 16'h0000;
    assign bcr              = bcr_q;
endmodule
